liang_issue_ctrl: RTL and testbench
===================================

Name: liang_issue_ctrl

Overview:
- In-order, single-issue scheduler between the decoder and the functional units of the liang core.
- Holds one decoded uop_info_t in an issue register and tracks pending destination registers in a 32-entry scoreboard.
- Dispatches the uop to the ALU or LSU only when there is no RAW/WAW hazard and the target unit is ready.
- Also limits the number of outstanding LSU operations.

Parameters:
- NUM_REGS, 32, number of architectural registers tracked by the scoreboard; x0 is never tracked.
- LSU_MAX_OUTST, 2, maximum LSU operations dispatched but not yet completed (1..7).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- dec_valid_i  in  1  decoder offers a uop.
- dec_ready_o  out  1  issue register can accept a uop this cycle.
- dec_uop_i  in  $bits(uop_info_t)=100  decoded uop.
- alu_valid_o  out  1  dispatch to ALU.
- alu_ready_i  in  1  ALU accepts.
- lsu_valid_o  out  1  dispatch to LSU.
- lsu_ready_i  in  1  LSU accepts.
- iss_uop_o  out  100  contents of the issue register (shared by ALU and LSU).
- wb_valid_i  in  1  a writeback is completing.
- wb_rd_i  in  5  destination of the completing writeback.
- lsu_done_i  in  1  one LSU operation has completed.
- flush_i  in  1  kill the held uop.
- illegal_o  out  1  one-cycle pulse when a FU_MFPU uop is dropped.
- sb_busy_o  out  32  current scoreboard; bit 0 is always 0.

Behaviour:
- Reset values: issue register invalid; state EMPTY; scoreboard 0; LSU outstanding count 0; all valid outputs 0; iss_uop_o 0; illegal_o 0. rst overrides every other input.
- States:
  - EMPTY: no uop held.
  - HELD: uop held and stalled or dispatching.
- EMPTY to HELD: on dec_valid_i && dec_ready_o.
- HELD to EMPTY: on dispatch, drop or flush with no new uop accepted. If a new uop is accepted in the same cycle, stay in HELD.
- Hazard check, combinational on the held uop:
  - eff_sb = sb & ~(wb_valid_i ? onehot(wb_rd_i) : 0), so a writeback clear is visible in the same cycle.
  - raw = eff_sb[rs1] | eff_sb[rs2], with x0 ignored.
  - waw = rd_wen && rd!=0 && eff_sb[rd].
- Dispatch:
  - alu_valid_o = HELD && fu==FU_ALU && !raw && !waw.
  - lsu_valid_o = HELD && fu==FU_LSU && !raw && !waw && lsu_cnt<LSU_MAX_OUTST.
  - Dispatch fires on valid && ready. Valid may depend on ready only through the stall terms; it never uses ready combinationally.
- FU_NONE: retires in 1 cycle while HELD, with no dispatch and no scoreboard set.
- FU_MFPU: dropped in 1 cycle; illegal_o pulses.
- dec_ready_o = EMPTY || dispatch || retire/drop. This gives back-to-back throughput of 1 uop/cycle with no bubble.
- Scoreboard:
  - On dispatch with rd_wen && rd!=0: set sb[rd].
  - On wb_valid_i: clear sb[wb_rd_i].
  - Same rd set and cleared in one cycle: set wins.
  - wb_rd_i==0: no effect.
- LSU count: +1 on LSU dispatch, -1 on lsu_done_i; both in one cycle leaves it unchanged. lsu_done_i at count 0 is ignored and the count saturates.
- flush_i: invalidates the held uop with no dispatch that cycle (valids forced 0). dec_ready_o is 1 and a uop offered in the same cycle is accepted. The scoreboard and LSU count are not cleared, because in-flight operations still complete.

Optional Feature:
- Macro: LIANG_ISSUE_PERF_EN.
- Defined:
  - Adds 32-bit wrapping counters perf_raw_o (HELD cycles stalled by raw|waw), perf_fu_o (HELD, hazard-free, but FU not ready or LSU limit reached) and perf_issue_o (dispatch count).
  - All counters reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Add to liang_pkg:
  - typedef enum logic {ISS_EMPTY, ISS_HELD} issue_state_e;
  - typedef logic [31:0] sb_t;
  - localparam int unsigned NUM_ARCH_REGS = 32.
- Sub-module liang_scoreboard: set/clear ports, eff_sb output and set-wins rule. It is reusable by a later dual-issue scheduler.

Test Plan:
- Back-to-back ALU ops:
  - Stimulus: ADD x1,x2,x3 then ADD x4,x5,x6, alu_ready_i=1.
  - Response: dispatched on consecutive cycles; sb_busy_o=0x12 until writebacks.
- RAW stall:
  - Stimulus: ADDI x5 dispatched, then ADD x6,x5,x0.
  - Response: the ADD holds with alu_valid_o=0 until wb_valid_i with wb_rd_i=5, and dispatches in that same cycle.
- LSU limit with LSU_MAX_OUTST=2:
  - Stimulus: three LW ops with independent registers and no lsu_done_i.
  - Response: the third LW is held; after one lsu_done_i pulse it dispatches the next cycle.
- Set/clear collision:
  - Stimulus: wb clear of x7 in the same cycle as dispatch of a new writer of x7.
  - Response: sb_busy_o[7]=1 afterwards.
- Flush:
  - Stimulus: held SW stalled on FU ready; flush_i with dec_valid_i asserted in the same cycle.
  - Response: the SW is never dispatched, the new uop is captured, and the scoreboard is unchanged.
- Reset mid-stall, plus illegal uop:
  - Stimulus: rst asserted while HELD with sb=0xFFFE.
  - Response: next cycle all outputs are 0.
  - Stimulus: a FU_MFPU uop.
  - Response: exactly one illegal_o pulse.

Source files
------------

// File: rtl/liang_pkg.sv
// Shared types for the liang issue stage: functional-unit codes, the decoded
// uop layout, issue FSM states and the scoreboard vector type.
package liang_pkg;

  localparam int unsigned NUM_ARCH_REGS = 32;

  typedef logic [31:0] sb_t;

  typedef enum logic [1:0] {
    FU_NONE = 2'd0,
    FU_ALU  = 2'd1,
    FU_LSU  = 2'd2,
    FU_MFPU = 2'd3
  } fu_e;

  typedef enum logic {
    ISS_EMPTY = 1'b0,
    ISS_HELD  = 1'b1
  } issue_state_e;

  // Decoded uop, 100 bits. Unused source fields are zeroed by the decoder so
  // that they read as x0 and never create a false dependency.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_branch;
    fu_e         fu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_wen;
  } uop_info_t;

  // True for the units that actually receive a dispatch handshake.
  function automatic logic fu_dispatches(input fu_e fu);
    logic res;
    case (fu)
      FU_ALU:  res = 1'b1;
      FU_LSU:  res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/liang_issue_ctrl_if.sv
// Decoder / functional-unit / writeback bundle of the liang issue stage.
// The slave modport is the issue controller; master is its surroundings.
interface liang_issue_ctrl_if;
  import liang_pkg::*;

  logic      dec_valid_i;
  logic      dec_ready_o;
  uop_info_t dec_uop_i;
  logic      alu_valid_o;
  logic      alu_ready_i;
  logic      lsu_valid_o;
  logic      lsu_ready_i;
  uop_info_t iss_uop_o;
  logic      wb_valid_i;
  logic [4:0] wb_rd_i;
  logic      lsu_done_i;
  logic      flush_i;
  logic      illegal_o;
  sb_t       sb_busy_o;

  modport slave (
    input  dec_valid_i, dec_uop_i, alu_ready_i, lsu_ready_i,
    input  wb_valid_i, wb_rd_i, lsu_done_i, flush_i,
    output dec_ready_o, alu_valid_o, lsu_valid_o, iss_uop_o,
    output illegal_o, sb_busy_o
  );

  modport master (
    output dec_valid_i, dec_uop_i, alu_ready_i, lsu_ready_i,
    output wb_valid_i, wb_rd_i, lsu_done_i, flush_i,
    input  dec_ready_o, alu_valid_o, lsu_valid_o, iss_uop_o,
    input  illegal_o, sb_busy_o
  );

endinterface

// File: rtl/liang_scoreboard.sv
// Pending-destination scoreboard. One set port (dispatch) and one clear port
// (writeback); a same-cycle set and clear of one register leaves it set.
// eff_sb already has this cycle's clear applied so consumers see a completing
// writeback immediately. Register 0 is never tracked.
module liang_scoreboard
  import liang_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_ARCH_REGS,
  localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [IDX_W-1:0]    set_idx,
  input  logic                clr_en,
  input  logic [IDX_W-1:0]    clr_idx,
  output logic [NUM_REGS-1:0] sb_q,
  output logic [NUM_REGS-1:0] eff_sb
);

  logic [NUM_REGS-1:0] sb_r;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] clr_mask_s;

  // Decode set/clear requests into one-hot masks, ignoring register 0
  always_comb begin
    set_mask_s = {NUM_REGS{1'b0}};
    clr_mask_s = {NUM_REGS{1'b0}};
    if (set_en && (set_idx != {IDX_W{1'b0}})) begin
      set_mask_s[set_idx] = 1'b1;
    end else begin
      set_mask_s = {NUM_REGS{1'b0}};
    end
    if (clr_en && (clr_idx != {IDX_W{1'b0}})) begin
      clr_mask_s[clr_idx] = 1'b1;
    end else begin
      clr_mask_s = {NUM_REGS{1'b0}};
    end
  end

  assign eff_sb = sb_r & ~clr_mask_s;
  assign sb_q   = sb_r;

  // Apply clear first, then set, so a colliding set wins
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_r <= {NUM_REGS{1'b0}};
    end else begin
      sb_r <= eff_sb | set_mask_s;
    end
  end

endmodule

// File: rtl/liang_issue_ctrl.sv
// In-order single-issue scheduler of the liang core. Holds one decoded uop,
// checks RAW/WAW against the scoreboard and dispatches to ALU or LSU, keeping
// at most LSU_MAX_OUTST LSU operations in flight.
// Optional: define LIANG_ISSUE_PERF_EN to add stall/issue performance counters.
module liang_issue_ctrl
  import liang_pkg::*;
#(
  parameter int unsigned NUM_REGS      = NUM_ARCH_REGS,
  parameter int unsigned LSU_MAX_OUTST = 2
) (
  input  logic               clk,
  input  logic               rst,
`ifdef LIANG_ISSUE_PERF_EN
  output logic [31:0]        perf_raw_o,
  output logic [31:0]        perf_fu_o,
  output logic [31:0]        perf_issue_o,
`endif
  liang_issue_ctrl_if.slave  bus
);

  localparam logic [2:0] LSU_MAX = LSU_MAX_OUTST[2:0];

  issue_state_e        state_r;
  issue_state_e        state_next_s;
  uop_info_t           uop_r;
  logic [2:0]          lsu_cnt_r;
  logic                illegal_r;

  logic [NUM_REGS-1:0] sb_q_s;
  logic [NUM_REGS-1:0] eff_sb_s;

  logic held_s, live_s, raw_s, waw_s, hazard_s, lsu_room_s;
  logic alu_valid_s, lsu_valid_s, alu_fire_s, lsu_fire_s;
  logic retire_s, drop_s, free_s, dec_ready_s, accept_s;
  logic sb_set_s, lsu_dec_s;

  liang_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (sb_set_s),
    .set_idx (uop_r.rd),
    .clr_en  (bus.wb_valid_i),
    .clr_idx (bus.wb_rd_i),
    .sb_q    (sb_q_s),
    .eff_sb  (eff_sb_s)
  );

  // Hazard check and dispatch/retire/drop decisions for the held uop.
  // Valids depend on the held uop, scoreboard and LSU count only; ready is
  // used solely to form the fire terms.
  always_comb begin
    held_s      = (state_r == ISS_HELD);
    live_s      = held_s && !bus.flush_i && !rst;
    raw_s       = ((uop_r.rs1 != 5'd0) && eff_sb_s[uop_r.rs1]) ||
                  ((uop_r.rs2 != 5'd0) && eff_sb_s[uop_r.rs2]);
    waw_s       = uop_r.rd_wen && (uop_r.rd != 5'd0) && eff_sb_s[uop_r.rd];
    hazard_s    = raw_s || waw_s;
    lsu_room_s  = (lsu_cnt_r < LSU_MAX);
    alu_valid_s = live_s && (uop_r.fu == FU_ALU) && !hazard_s;
    lsu_valid_s = live_s && (uop_r.fu == FU_LSU) && !hazard_s && lsu_room_s;
    alu_fire_s  = alu_valid_s && bus.alu_ready_i;
    lsu_fire_s  = lsu_valid_s && bus.lsu_ready_i;
    retire_s    = live_s && (uop_r.fu == FU_NONE);
    drop_s      = live_s && (uop_r.fu == FU_MFPU);
    free_s      = !held_s || alu_fire_s || lsu_fire_s || retire_s || drop_s ||
                  bus.flush_i;
    dec_ready_s = free_s && !rst;
    accept_s    = bus.dec_valid_i && dec_ready_s;
    sb_set_s    = (alu_fire_s || lsu_fire_s) && uop_r.rd_wen &&
                  (uop_r.rd != 5'd0);
    lsu_dec_s   = bus.lsu_done_i && (lsu_cnt_r != 3'd0);
  end

  // Next issue state: a new uop keeps us HELD, a vacated slot goes EMPTY
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ISS_EMPTY: begin
        if (accept_s) state_next_s = ISS_HELD;
        else          state_next_s = ISS_EMPTY;
      end
      ISS_HELD: begin
        if (accept_s)    state_next_s = ISS_HELD;
        else if (free_s) state_next_s = ISS_EMPTY;
        else             state_next_s = ISS_HELD;
      end
      default: state_next_s = ISS_EMPTY;
    endcase
  end

  // Issue register and state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ISS_EMPTY;
      uop_r   <= '0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        uop_r <= bus.dec_uop_i;
      end
    end
  end

  // Outstanding LSU count; a done at zero is ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      lsu_cnt_r <= 3'd0;
    end else begin
      case ({lsu_fire_s, lsu_dec_s})
        2'b10:   lsu_cnt_r <= lsu_cnt_r + 3'd1;
        2'b01:   lsu_cnt_r <= lsu_cnt_r - 3'd1;
        default: lsu_cnt_r <= lsu_cnt_r;
      endcase
    end
  end

  // One-cycle illegal pulse following the drop of an MFPU uop
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= drop_s;
    end
  end

  assign bus.dec_ready_o = dec_ready_s;
  assign bus.alu_valid_o = alu_valid_s;
  assign bus.lsu_valid_o = lsu_valid_s;
  assign bus.iss_uop_o   = uop_r;
  assign bus.illegal_o   = illegal_r;
  assign bus.sb_busy_o   = sb_q_s;

`ifdef LIANG_ISSUE_PERF_EN
  logic [31:0] perf_raw_r, perf_fu_r, perf_issue_r;
  logic        stall_haz_s, stall_fu_s, issue_s;

  assign issue_s     = alu_fire_s || lsu_fire_s;
  assign stall_haz_s = live_s && fu_dispatches(uop_r.fu) && hazard_s;
  assign stall_fu_s  = live_s && fu_dispatches(uop_r.fu) && !hazard_s && !issue_s;

  // Wrapping stall and issue counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_raw_r   <= 32'd0;
      perf_fu_r    <= 32'd0;
      perf_issue_r <= 32'd0;
    end else begin
      perf_raw_r   <= perf_raw_r   + {31'd0, stall_haz_s};
      perf_fu_r    <= perf_fu_r    + {31'd0, stall_fu_s};
      perf_issue_r <= perf_issue_r + {31'd0, issue_s};
    end
  end

  assign perf_raw_o   = perf_raw_r;
  assign perf_fu_o    = perf_fu_r;
  assign perf_issue_o = perf_issue_r;
`endif

endmodule

// File: tb/tb_liang_issue_ctrl.sv
// Bench for liang_issue_ctrl: directed scenarios followed by random traffic,
// all checked against a transaction-level model (queue of pending dispatches,
// busy-register set, LSU in-flight count). A monitor pops the expected
// dispatch queue whenever the DUT fires a valid/ready handshake.
module tb_liang_issue_ctrl;
  import liang_pkg::*;

  localparam int MAXO = 2;

  typedef struct {
    bit        lsu;
    uop_info_t u;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  liang_issue_ctrl_if bus();

  liang_issue_ctrl #(.NUM_REGS(32), .LSU_MAX_OUTST(MAXO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_held = 1'b0;
  uop_info_t   m_uop  = '0;
  logic [31:0] m_busy = 32'd0;
  int          m_cnt  = 0;
  bit          m_ill  = 1'b0;
  int          exp_ill = 0;
  int          seen_ill = 0;
  exp_t        exp_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic uop_info_t mk(input fu_e f, input int rd, input int rs1,
                                   input int rs2, input bit wen);
    uop_info_t u;
    u.pc        = $urandom;
    u.imm       = $urandom;
    u.opcode    = 7'($urandom);
    u.funct3    = 3'($urandom);
    u.funct7    = 7'($urandom);
    u.is_branch = 1'($urandom);
    u.fu        = f;
    u.rs1       = 5'(rs1);
    u.rs2       = 5'(rs2);
    u.rd        = 5'(rd);
    u.rd_wen    = wen;
    return u;
  endfunction

  // Model one cycle from the inputs just driven: compare, then advance.
  task automatic step();
    logic [31:0] eff;
    bit haz, live, ea, el, fa, fl, rdy;
    int c0;
    eff = m_busy;
    if (bus.wb_valid_i) eff[bus.wb_rd_i] = 1'b0;
    haz  = (m_uop.rs1 != 0 && eff[m_uop.rs1]) || (m_uop.rs2 != 0 && eff[m_uop.rs2]) ||
           (m_uop.rd_wen && m_uop.rd != 0 && eff[m_uop.rd]);
    live = m_held && !bus.flush_i && !rst;
    ea   = live && m_uop.fu == FU_ALU && !haz;
    el   = live && m_uop.fu == FU_LSU && !haz && (m_cnt < MAXO);
    fa   = ea && bus.alu_ready_i;
    fl   = el && bus.lsu_ready_i;
    rdy  = !rst && (!m_held || bus.flush_i || fa || fl ||
                    (live && (m_uop.fu == FU_NONE || m_uop.fu == FU_MFPU)));
    chk("dec_ready", bus.dec_ready_o, rdy);
    chk("alu_valid", bus.alu_valid_o, ea);
    chk("lsu_valid", bus.lsu_valid_o, el);
    chk("sb_busy", bus.sb_busy_o, m_busy);
    chk("illegal", bus.illegal_o, m_ill);
    if (m_held) chk("iss_uop", bus.iss_uop_o, m_uop);
    if (rst) begin
      m_held = 1'b0; m_uop = '0; m_busy = 32'd0; m_cnt = 0; m_ill = 1'b0;
      exp_q.delete();
    end else begin
      m_ill = live && m_uop.fu == FU_MFPU;
      if (m_ill) exp_ill++;
      if (m_held && bus.flush_i && (m_uop.fu == FU_ALU || m_uop.fu == FU_LSU))
        void'(exp_q.pop_back());
      m_busy = eff;
      if ((fa || fl) && m_uop.rd_wen && m_uop.rd != 0) m_busy[m_uop.rd] = 1'b1;
      c0 = m_cnt;
      m_cnt = c0 + (fl ? 1 : 0) - ((bus.lsu_done_i && c0 > 0) ? 1 : 0);
      if (bus.dec_valid_i && rdy) begin
        m_held = 1'b1;
        m_uop  = bus.dec_uop_i;
        if (bus.dec_uop_i.fu == FU_ALU) exp_q.push_back('{1'b0, bus.dec_uop_i});
        if (bus.dec_uop_i.fu == FU_LSU) exp_q.push_back('{1'b1, bus.dec_uop_i});
      end else if (rdy) begin
        m_held = 1'b0;
      end
    end
  endtask

  task automatic cyc(input bit dv, input uop_info_t u, input bit ar, input bit lr,
                     input bit wv, input logic [4:0] wr, input bit ld, input bit fl,
                     input bit r);
    @(negedge clk);
    bus.dec_valid_i = dv;
    bus.dec_uop_i   = u;
    bus.alu_ready_i = ar;
    bus.lsu_ready_i = lr;
    bus.wb_valid_i  = wv;
    bus.wb_rd_i     = wr;
    bus.lsu_done_i  = ld;
    bus.flush_i     = fl;
    rst             = r;
    #1;
    step();
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mon_take(input bit lsu, input uop_info_t got);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL dispatch_unexpected: got unit=%0d uop=%0h want none", lsu, got);
    end else begin
      e = exp_q.pop_front();
      chk("dispatch_unit", lsu, e.lsu);
      chk("dispatch_uop", got, e.u);
    end
  endtask

  // Monitor: sample handshakes just before the active edge
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (bus.alu_valid_o && bus.alu_ready_i) mon_take(1'b0, bus.iss_uop_o);
      if (bus.lsu_valid_o && bus.lsu_ready_i) mon_take(1'b1, bus.iss_uop_o);
      if (bus.illegal_o) seen_ill++;
    end
  end

  initial begin
    uop_info_t u, n;
    int s0;
    bus.dec_valid_i = 1'b0; bus.dec_uop_i = '0; bus.alu_ready_i = 1'b0;
    bus.lsu_ready_i = 1'b0; bus.wb_valid_i = 1'b0; bus.wb_rd_i = 5'd0;
    bus.lsu_done_i = 1'b0; bus.flush_i = 1'b0;

    // reset
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("rst_sb", bus.sb_busy_o, 32'd0);
    chk("rst_iss", bus.iss_uop_o, 100'd0);
    chk("rst_ready", bus.dec_ready_o, 1'b1);

    // back-to-back ALU
    cyc(1'b1, mk(FU_ALU, 1, 2, 3, 1'b1), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(FU_ALU, 4, 5, 6, 1'b1), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("b2b_first", bus.alu_valid_o, 1'b1);
    idle();
    chk("b2b_second", bus.alu_valid_o, 1'b1);
    idle();
    chk("b2b_sb", bus.sb_busy_o, 32'h12);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);

    // RAW stall released by a same-cycle writeback
    cyc(1'b1, mk(FU_ALU, 5, 0, 0, 1'b1), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(FU_ALU, 6, 5, 0, 1'b1), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("raw_stall", bus.alu_valid_o, 1'b0);
    end
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("raw_wb_release", bus.alu_valid_o, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);

    // LSU outstanding limit
    cyc(1'b1, mk(FU_LSU, 10, 0, 0, 1'b1), 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(FU_LSU, 11, 0, 0, 1'b1), 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(FU_LSU, 12, 0, 0, 1'b1), 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("lsu_limit", bus.lsu_valid_o, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("lsu_limit_done_cycle", bus.lsu_valid_o, 1'b0);
    idle();
    chk("lsu_after_done", bus.lsu_valid_o, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

    // set/clear collision on x7
    cyc(1'b1, mk(FU_ALU, 7, 0, 0, 1'b1), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(FU_ALU, 7, 0, 0, 1'b1), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    chk("collide_dispatch", bus.alu_valid_o, 1'b1);
    idle();
    chk("collide_set_wins", bus.sb_busy_o[7], 1'b1);

    // flush of a stalled SW with a new uop in the same cycle
    cyc(1'b1, mk(FU_LSU, 0, 0, 0, 1'b0), 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("sw_offered", bus.lsu_valid_o, 1'b1);
    n = mk(FU_ALU, 8, 0, 0, 1'b1);
    cyc(1'b1, n, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("flush_no_lsu", bus.lsu_valid_o, 1'b0);
    chk("flush_ready", bus.dec_ready_o, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("flush_capture", bus.iss_uop_o, n);
    chk("flush_sb", bus.sb_busy_o, 32'h80);
    idle();

    // reset while stalled with 0xFFFE busy
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int r = 1; r < 16; r++)
      cyc(1'b1, mk(FU_ALU, r, 0, 0, 1'b1), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(FU_ALU, 0, 1, 0, 1'b0), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("stall_sb", bus.sb_busy_o, 32'hFFFE);
    chk("stall_alu", bus.alu_valid_o, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("midrst_sb", bus.sb_busy_o, 32'd0);
    chk("midrst_alu", bus.alu_valid_o, 1'b0);
    chk("midrst_lsu", bus.lsu_valid_o, 1'b0);
    chk("midrst_iss", bus.iss_uop_o, 100'd0);
    chk("midrst_ill", bus.illegal_o, 1'b0);

    // illegal MFPU uop: exactly one pulse
    s0 = seen_ill;
    cyc(1'b1, mk(FU_MFPU, 3, 0, 0, 1'b1), 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle();
    chk("illegal_one_pulse", seen_ill - s0, 1);
    chk("illegal_no_sb", bus.sb_busy_o, 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      fu_e f;
      case ($urandom_range(9))
        0:       f = FU_NONE;
        1:       f = FU_MFPU;
        2, 3, 4: f = FU_LSU;
        default: f = FU_ALU;
      endcase
      u = mk(f, $urandom_range(7), $urandom_range(7), $urandom_range(7), 1'($urandom_range(1)));
      cyc($urandom_range(3) != 0, u, $urandom_range(3) != 0, $urandom_range(2) != 0,
          $urandom_range(2) == 0, 5'($urandom_range(7)), $urandom_range(3) == 0,
          $urandom_range(24) == 0, $urandom_range(199) == 0);
    end
    for (int i = 0; i < 4; i++) idle();
    chk("illegal_count", seen_ill, exp_ill);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
